fft32_input_loader: RTL and testbench
=====================================

# fft32_input_loader

Streaming front end for the 32-point radix-2 FFT datapath. It accepts one complex sample per cycle over a valid/ready handshake and assembles 32-sample frames in a ping-pong register buffer. Each sample is written to its bit-reversed slot. Each completed frame is presented as a flat parallel bus that feeds the 32-input butterfly network directly, and is held until the consumer acknowledges it.

## Interface

Parameters:
- DATA_W, 32, width of each real/imag component, two's complement
- BITREV, 1, 1 = store sample n at slot bitrev5(n); 0 = natural order

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- s_valid  in  1  input sample valid
- s_ready  out  1  loader can accept a sample this cycle
- s_r  in  DATA_W  sample real part
- s_i  in  DATA_W  sample imaginary part
- s_last  in  1  marks sample 31 of a frame
- frame_valid  out  1  a complete frame is on out_r/out_i
- frame_ack  in  1  consumer takes the presented frame
- out_r  out  32*DATA_W  slot k at bits [k*DATA_W +: DATA_W]
- out_i  out  32*DATA_W  same packing, imaginary parts
- err  out  1  one-cycle pulse on framing error

## Operation

- Storage: two banks (B0, B1). Each bank is 32 entries × 2·DATA_W.
- Per-bank full flag: full[1:0].
- Write side: 5-bit counter cnt and wr_bank pointer.
- Read side: rd_bank pointer.
- s_ready = ~full[wr_bank] & rst.
- Accept: s_valid & s_ready. The sample is written to slot (BITREV ? bitrev5(cnt) : cnt) of wr_bank, then cnt increments.
- Frame close: an accept with cnt==31 and s_last=1.
  - Sets full[wr_bank].
  - Toggles wr_bank.
  - Resets cnt to 0.
- Framing error: the partial frame is discarded, cnt goes to 0, the bank stays empty, and err pulses the next cycle. Either of these triggers it:
  - accept with s_last=1 and cnt≠31;
  - accept with cnt==31 and s_last=0.
- frame_valid = full[rd_bank], registered.
- out_r/out_i are always driven from rd_bank.
- Consumption: frame_ack & frame_valid clears full[rd_bank] and toggles rd_bank.
- frame_ack while frame_valid=0 is ignored.
- Simultaneous events:
  - Frame close on one bank and ack on the other in the same cycle are both honoured.
  - A close and an ack on the same bank cannot occur, because a full bank is never written.
- Reset (also when applied mid-frame):
  - cnt, wr_bank, rd_bank, full and err go to 0.
  - All storage is cleared to 0.
  - Any partial or held frame is lost.

## Timing

- Reset values:
  - s_ready=0 while rst=0, and 1 in the first cycle after release.
  - frame_valid=0, err=0.
  - out_r=0, out_i=0.
- Latency: last sample accepted at edge T → frame_valid=1 and the data stable from T+1.
- Hold: outputs are stable while frame_valid=1 and no ack is given.
- After an ack at edge T:
  - at T+1, outputs switch to the other bank;
  - frame_valid stays 1 if that bank is full, else it falls at T+1.
- Back-pressure:
  - s_ready falls in the cycle after the edge that fills the second bank.
  - s_ready rises in the cycle after the ack that frees wr_bank.
- Throughput: sustained 1 sample/cycle when each frame is acked within 32 cycles of frame_valid.
- Arithmetic: no arithmetic on the data path; values pass through unmodified.
- cnt wraps 31→0 only on a frame close or an error.

## Structure

- Shared package fft32_pkg holds:
  - FFT_N=32, FFT_LOG2N=5, DATA_W=32;
  - function bitrev5.
- The Butterfly stages use the same constants.
- Sub-module fft32_frame_bank is instantiated twice. It is one 32-entry bank with:
  - synchronous write port (we, addr, din_r, din_i);
  - synchronous clear;
  - full parallel flat read.
- Top level: handshake, counter, pointers, full flags, error logic, output mux.

## Test plan

- Basic frame (BITREV=1): after reset, stream n=0..31 with s_r=n, s_i=−n and s_last on n=31.
  - frame_valid at T+1.
  - Slot 1 = (16,−16), slot 2 = (8,−8), slot 31 = (31,−31).
- Back-pressure: three frames back-to-back with frame_ack=0.
  - s_ready=0 after the 64th accept; frame 1 is held.
  - One ack → frame 2 visible at T+1 and s_ready=1.
  - Frame 3 completes.
- Early s_last: s_last at n=10.
  - err pulses one cycle; no frame_valid.
  - The next 32 samples form a correct frame.
- Missing s_last: 32nd sample without s_last.
  - err pulses; frame is discarded; s_ready stays 1.
- Simultaneous close and ack: ack frame A in the same cycle that frame B's 32nd sample is accepted.
  - frame_valid stays 1 and outputs show B at T+1.
- Reset and natural order: rst=0 after 20 samples.
  - No frame_valid; all outputs 0.
  - Repeat the basic frame with BITREV=0 → slot k = (k,−k).

Source files
------------

// File: rtl/fft32_pkg.sv
// Constants shared by the 32-point FFT front end and butterfly stages,
// plus the 5-bit index reversal used for bit-reversed frame loading.
package fft32_pkg;

  localparam int FFT_N     = 32;
  localparam int FFT_LOG2N = 5;
  localparam int DATA_W    = 32;

  function automatic logic [FFT_LOG2N-1:0] bitrev5(input logic [FFT_LOG2N-1:0] n);
    logic [FFT_LOG2N-1:0] r;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      r[b] = n[FFT_LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft32_input_loader_if.sv
// Sample stream in, parallel frame out; master drives samples and acks,
// slave (the loader) returns ready, the held frame and the error pulse.
interface fft32_input_loader_if import fft32_pkg::*; #(
  parameter int DATA_W = fft32_pkg::DATA_W
);

  logic                      s_valid;
  logic                      s_ready;
  logic [DATA_W-1:0]         s_r;
  logic [DATA_W-1:0]         s_i;
  logic                      s_last;
  logic                      frame_valid;
  logic                      frame_ack;
  logic [FFT_N*DATA_W-1:0]   out_r;
  logic [FFT_N*DATA_W-1:0]   out_i;
  logic                      err;

  modport master (
    output s_valid, s_r, s_i, s_last, frame_ack,
    input  s_ready, frame_valid, out_r, out_i, err
  );

  modport slave (
    input  s_valid, s_r, s_i, s_last, frame_ack,
    output s_ready, frame_valid, out_r, out_i, err
  );

endinterface

// File: rtl/fft32_frame_bank.sv
// One 32-entry complex sample bank: single write port, synchronous clear,
// every slot visible at once on a flat bus for the butterfly network.
module fft32_frame_bank import fft32_pkg::*; #(
  parameter int DATA_W = fft32_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    we,
  input  logic [FFT_LOG2N-1:0]    addr,
  input  logic [DATA_W-1:0]       din_r,
  input  logic [DATA_W-1:0]       din_i,
  output logic [FFT_N*DATA_W-1:0] dout_r,
  output logic [FFT_N*DATA_W-1:0] dout_i
);

  genvar gi;
  generate
    for (gi = 0; gi < FFT_N; gi++) begin : g_slot
      logic [DATA_W-1:0] r_q, r_d;
      logic [DATA_W-1:0] i_q, i_d;

      always_comb begin
        r_d = r_q;
        i_d = i_q;
        if (clr) begin
          r_d = '0;
          i_d = '0;
        end else if (we && (addr == FFT_LOG2N'(gi))) begin
          r_d = din_r;
          i_d = din_i;
        end
      end

      always_ff @(posedge clk) begin
        r_q <= r_d;
        i_q <= i_d;
      end

      assign dout_r[gi*DATA_W +: DATA_W] = r_q;
      assign dout_i[gi*DATA_W +: DATA_W] = i_q;
    end
  endgenerate

endmodule

// File: rtl/fft32_input_loader.sv
// Streaming loader: assembles 32-sample frames into a ping-pong pair of
// banks and holds each completed frame on a parallel bus until acked.
module fft32_input_loader import fft32_pkg::*; #(
  parameter int DATA_W = fft32_pkg::DATA_W,
  parameter bit BITREV = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  fft32_input_loader_if.slave bus
);

  logic [FFT_LOG2N-1:0] cnt_q, cnt_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [1:0]           full_q, full_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 at_last_slot;
  logic                 close;
  logic                 frame_err;
  logic                 take;
  logic                 clr;
  logic [FFT_LOG2N-1:0] wr_addr;

  logic [FFT_N*DATA_W-1:0] bank_r [2];
  logic [FFT_N*DATA_W-1:0] bank_i [2];

  // A full bank is never written, so close and ack can never hit the same bank.
  assign bus.s_ready  = ~full_q[wr_bank_q] & rst;
  assign accept       = bus.s_valid & bus.s_ready;
  assign at_last_slot = (cnt_q == FFT_LOG2N'(FFT_N - 1));
  assign close        = accept & at_last_slot & bus.s_last;
  assign frame_err    = accept & (at_last_slot ^ bus.s_last);
  assign take         = bus.frame_ack & full_q[rd_bank_q];
  assign clr          = ~rst;
  assign wr_addr      = BITREV ? bitrev5(cnt_q) : cnt_q;

  always_comb begin
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    err_d     = frame_err;
    if (accept) begin
      cnt_d = (close || frame_err) ? '0 : cnt_q + FFT_LOG2N'(1);
    end
    if (close) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (take) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      fft32_frame_bank #(.DATA_W(DATA_W)) u_bank (
        .clk    (clk),
        .clr    (clr),
        .we     (accept && (wr_bank_q == 1'(gi))),
        .addr   (wr_addr),
        .din_r  (bus.s_r),
        .din_i  (bus.s_i),
        .dout_r (bank_r[gi]),
        .dout_i (bank_i[gi])
      );
    end
  endgenerate

  assign bus.out_r       = bank_r[rd_bank_q];
  assign bus.out_i       = bank_i[rd_bank_q];
  assign bus.frame_valid = full_q[rd_bank_q];
  assign bus.err         = err_q;

endmodule

// File: tb/tb_fft32_input_loader.sv
// Drives one sample stream into a bit-reversed and a natural-order loader;
// a frame-level model feeds a scoreboard that a negedge monitor checks.
module tb_fft32_input_loader;

  localparam int W = 32;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         s_valid   = 1'b0;
  logic         s_last    = 1'b0;
  logic         frame_ack = 1'b0;
  logic [W-1:0] s_r       = '0;
  logic [W-1:0] s_i       = '0;

  fft32_input_loader_if #(.DATA_W(W)) if_br ();
  fft32_input_loader_if #(.DATA_W(W)) if_nat ();

  assign if_br.s_valid    = s_valid;
  assign if_br.s_r        = s_r;
  assign if_br.s_i        = s_i;
  assign if_br.s_last     = s_last;
  assign if_br.frame_ack  = frame_ack;
  assign if_nat.s_valid   = s_valid;
  assign if_nat.s_r       = s_r;
  assign if_nat.s_i       = s_i;
  assign if_nat.s_last    = s_last;
  assign if_nat.frame_ack = frame_ack;

  fft32_input_loader #(.DATA_W(W), .BITREV(1'b1)) dut_br (
    .clk (clk),
    .rst (rst),
    .bus (if_br)
  );

  fft32_input_loader #(.DATA_W(W), .BITREV(1'b0)) dut_nat (
    .clk (clk),
    .rst (rst),
    .bus (if_nat)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: completed frames in natural sample order, oldest first.
  logic [N*W-1:0] sb_r[$];
  logic [N*W-1:0] sb_i[$];
  logic [N*W-1:0] part_r = '0;
  logic [N*W-1:0] part_i = '0;
  int  held      = 0;
  int  m_cnt     = 0;
  int  n_closed  = 0;
  bit  exp_err   = 1'b0;
  bit  zero_exp  = 1'b1;
  bit  skip      = 1'b1;

  function automatic int rev5(input int n);
    int r = 0;
    for (int b = 0; b < 5; b++) r = (r << 1) | ((n >> b) & 1);
    return r;
  endfunction

  task automatic cmp_bit(input string name, input string dn, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s [%s] got=%0b exp=%0b @%0t", name, dn, got, exp, $time);
    end
  endtask

  task automatic cmp_frame(input string name, input string dn,
                           input logic [N*W-1:0] o_r, input logic [N*W-1:0] o_i,
                           input logic [N*W-1:0] e_r, input logic [N*W-1:0] e_i);
    int bad = -1;
    vectors++;
    if (o_r !== e_r || o_i !== e_i) begin
      miscompares++;
      for (int k = N - 1; k >= 0; k--)
        if (o_r[k*W +: W] !== e_r[k*W +: W] || o_i[k*W +: W] !== e_i[k*W +: W]) bad = k;
      $display("FAIL %s [%s] slot %0d got r=%h i=%h exp r=%h i=%h @%0t", name, dn, bad,
               o_r[bad*W +: W], o_i[bad*W +: W], e_r[bad*W +: W], e_i[bad*W +: W], $time);
    end
  endtask

  task automatic check_dut(input string dn, input bit br, input logic rdy, input logic fv,
                           input logic er, input logic [N*W-1:0] o_r, input logic [N*W-1:0] o_i);
    logic [N*W-1:0] e_r, e_i;
    int src;
    cmp_bit("s_ready", dn, rdy, rst && (held < 2));
    if (skip) return;
    cmp_bit("frame_valid", dn, fv, sb_r.size() > 0);
    cmp_bit("err", dn, er, exp_err);
    if (sb_r.size() > 0) begin
      for (int k = 0; k < N; k++) begin
        src = br ? rev5(k) : k;
        e_r[k*W +: W] = sb_r[0][src*W +: W];
        e_i[k*W +: W] = sb_i[0][src*W +: W];
      end
      cmp_frame("frame", dn, o_r, o_i, e_r, e_i);
    end else if (zero_exp) begin
      cmp_frame("reset_zero", dn, o_r, o_i, '0, '0);
    end
  endtask

  always @(negedge clk) begin
    check_dut("br",  1'b1, if_br.s_ready,  if_br.frame_valid,  if_br.err,  if_br.out_r,  if_br.out_i);
    check_dut("nat", 1'b0, if_nat.s_ready, if_nat.frame_valid, if_nat.err, if_nat.out_r, if_nat.out_i);
    if (!skip && rst && frame_ack && sb_r.size() > 0) begin
      void'(sb_r.pop_front());
      void'(sb_i.pop_front());
    end
  end

  task automatic step(input logic v, input logic [W-1:0] r, input logic [W-1:0] i,
                      input logic l, input logic a, output logic acc);
    logic take;
    s_valid   = v;
    s_r       = r;
    s_i       = i;
    s_last    = l;
    frame_ack = a;
    acc  = v && rst && (held < 2);
    take = a && rst && (held > 0);
    @(posedge clk);
    #1;
    exp_err = 1'b0;
    if (acc) begin
      zero_exp = 1'b0;
      part_r[m_cnt*W +: W] = r;
      part_i[m_cnt*W +: W] = i;
      if (l && m_cnt == N - 1) begin
        sb_r.push_back(part_r);
        sb_i.push_back(part_i);
        held++;
        n_closed++;
        m_cnt = 0;
        $display("frame %0d closed @%0t", n_closed, $time);
      end else if (l || m_cnt == N - 1) begin
        $display("framing error at sample %0d @%0t", m_cnt, $time);
        exp_err = 1'b1;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end
    if (take) held--;
  endtask

  task automatic idle(input int n, input logic a);
    logic acc;
    for (int c = 0; c < n; c++) step(1'b0, '0, '0, 1'b0, a, acc);
  endtask

  task automatic drain();
    int budget = 0;
    logic acc;
    while (held > 0) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc);
      budget++;
      if (budget > 100) begin
        miscompares++;
        $display("FAIL drain_timeout got held=%0d exp 0", held);
        break;
      end
    end
    idle(1, 1'b0);
  endtask

  // ack_mode: 0 none, 1 random, 2 one ack after 5 stalled cycles, 3 ack on final sample
  task automatic send_frame(input int n_samples, input int last_at, input int ack_mode,
                            input bit gaps, input bit ramp);
    int budget = 0;
    int stall  = 0;
    logic acc, v, a;
    logic [W-1:0] r, i;
    for (int idx = 0; idx < n_samples; idx++) begin
      r = ramp ? W'(idx) : W'($urandom);
      i = ramp ? W'(-idx) : W'($urandom);
      acc = 1'b0;
      while (!acc) begin
        v = gaps ? ($urandom_range(3) != 0) : 1'b1;
        case (ack_mode)
          1:       a = ($urandom_range(7) == 0);
          2:       a = (stall == 5);
          3:       a = (idx == n_samples - 1);
          default: a = 1'b0;
        endcase
        step(v, r, i, (idx == last_at), a, acc);
        if (v && !acc) stall++;
        budget++;
        if (budget > 3000) begin
          miscompares++;
          $display("FAIL send_timeout got accepted=%0d exp %0d", idx, n_samples);
          return;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    skip      = 1'b1;
    rst       = 1'b0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    frame_ack = 1'b0;
    @(posedge clk);
    #1;
    held = 0;
    m_cnt = 0;
    sb_r.delete();
    sb_i.delete();
    exp_err  = 1'b0;
    zero_exp = 1'b1;
    skip     = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1;
    rst = 1'b1;
    $display("reset released @%0t", $time);
  endtask

  initial begin
    do_reset(3);
    idle(2, 1'b0);

    // basic ramp frame, held then acked
    send_frame(32, 31, 0, 1'b0, 1'b1);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // back-pressure: two frames fill both banks, third stalls until one ack
    send_frame(32, 31, 0, 1'b0, 1'b0);
    send_frame(32, 31, 0, 1'b0, 1'b0);
    send_frame(32, 31, 2, 1'b0, 1'b0);
    idle(2, 1'b0);
    drain();

    // early s_last, then a clean frame
    send_frame(11, 10, 0, 1'b0, 1'b0);
    idle(2, 1'b0);
    send_frame(32, 31, 0, 1'b0, 1'b0);
    drain();

    // missing s_last on the 32nd sample
    send_frame(32, -1, 0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // ack frame A in the same cycle frame B closes
    send_frame(32, 31, 0, 1'b0, 1'b0);
    send_frame(32, 31, 3, 1'b0, 1'b0);
    idle(3, 1'b0);
    drain();

    // random traffic with gaps, random acks and occasional short frames
    for (int f = 0; f < 8; f++) begin
      int len;
      if ($urandom_range(3) == 0) begin
        len = $urandom_range(31, 1);
        send_frame(len, len - 1, 1, 1'b1, 1'b0);
      end else begin
        send_frame(32, 31, 1, 1'b1, 1'b0);
      end
    end
    drain();

    // mid-frame reset, then natural-order ramp frame
    send_frame(20, -1, 0, 1'b0, 1'b0);
    do_reset(2);
    idle(3, 1'b0);
    send_frame(32, 31, 0, 1'b0, 1'b1);
    idle(2, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got time=%0t exp completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
